// File: rtl/led_pkg.sv
// led_pkg: shared default constants for the LED PWM fader
package led_pkg;
    localparam int LED_NUM       = 8;
    localparam int LED_PWM_BITS  = 8;
    localparam int LED_PRESCALE  = 16;
    localparam int LED_FADE_STEP = 4;
endpackage

// File: rtl/led_fade_chan.sv
// led_fade_chan: one LED channel -- duty register, saturating ramp, PWM compare and pin flop
module led_fade_chan import led_pkg::*; #(
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int FADE_STEP  = LED_FADE_STEP,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                csi_clk,
    input  logic                rsi_reset,
    input  logic                pattern_bit,
    input  logic [PWM_BITS-1:0] max_duty,
    input  logic                fade_en,
    input  logic                bnd,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pin
);
    localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(FADE_STEP);
    logic [PWM_BITS-1:0] duty, target, ramp, duty_nxt;
    logic [PWM_BITS:0]   up, dn;
    // one extra bit keeps the ramp from wrapping so it saturates exactly at target
    always_comb begin
        target   = pattern_bit ? max_duty : '0;
        up       = {1'b0, duty} + STEP;
        dn       = {1'b0, target} + STEP;
        ramp     = duty < target ? (up > {1'b0, target} ? target : up[PWM_BITS-1:0]) :
                   duty > target ? (dn > {1'b0, duty} ? target : duty - STEP[PWM_BITS-1:0]) : duty;
        duty_nxt = fade_en ? ramp : target;
    end
    always_ff @(posedge csi_clk or posedge rsi_reset)
        if (rsi_reset) begin
            duty <= '0;
            pin  <= ACTIVE_LOW;
        end else begin
            if (bnd) duty <= duty_nxt;
            pin <= (duty > pwm_cnt) ^ ACTIVE_LOW;
        end
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns the LED register pattern into PWM-dimmed, optionally faded LED pins
module led_pwm_fader import led_pkg::*; #(
    parameter int NUM_LEDS   = LED_NUM,
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int PRESCALE   = LED_PRESCALE,
    parameter int FADE_STEP  = LED_FADE_STEP,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                csi_clk,
    input  logic                rsi_reset,
    input  logic [NUM_LEDS-1:0] led_pattern,
    input  logic [PWM_BITS-1:0] max_duty,
    input  logic                fade_en,
    output logic [NUM_LEDS-1:0] coe_led_pins,
    output logic                period_start
);
    localparam int              PS_W    = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    logic [NUM_LEDS-1:0] pattern_q;
    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick, bnd;
    assign tick = prescaler == PS_LAST;
    assign bnd  = tick && &pwm_cnt;
    always_ff @(posedge csi_clk or posedge rsi_reset)
        if (rsi_reset) begin
            pattern_q    <= '0;
            prescaler    <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            pattern_q    <= led_pattern;
            prescaler    <= tick ? '0 : prescaler + PS_W'(1);
            pwm_cnt      <= pwm_cnt + PWM_BITS'(tick);
            period_start <= bnd;
        end
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .csi_clk    (csi_clk),
            .rsi_reset  (rsi_reset),
            .pattern_bit(pattern_q[i]),
            .max_duty   (max_duty),
            .fade_en    (fade_en),
            .bnd        (bnd),
            .pwm_cnt    (pwm_cnt),
            .pin        (coe_led_pins[i])
        );
    end
endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
Downstream stage of the Avalon-MM LED control register. It consumes the 8-bit LED pattern that the register block drives on its conduit and turns each bit into a PWM-dimmed, optionally faded, physical LED pin. It sits between the LED register slave and the board pins in the same clock domain, so no CDC is required. Brightness changes apply only at PWM period boundaries, so pins never glitch mid-period.

Parameters:
NUM_LEDS, 8, number of LED channels (matches the register block's LED conduit width)
PWM_BITS, 8, PWM counter and duty width
PRESCALE, 16, csi_clk cycles per PWM counter step (>=1)
FADE_STEP, 4, duty change per PWM period when fading (1..2^PWM_BITS-1)
ACTIVE_LOW, 0, 1 = pins are driven low for LED on

Ports:
csi_clk  in  1  system clock
rsi_reset  in  1  reset; asynchronous, active-high
led_pattern  in  NUM_LEDS  on/off pattern from the LED register conduit
max_duty  in  PWM_BITS  duty used for an "on" LED (global brightness)
fade_en  in  1  1 = ramp duty by FADE_STEP per period; 0 = step directly to target
coe_led_pins  out  NUM_LEDS  physical LED drive
period_start  out  1  one-cycle pulse marking the first cycle of each PWM period

Behaviour:
- Single clock, csi_clk. rsi_reset is asynchronous, active-high. All flops clear on reset assertion.
- Reset values: prescaler=0, pwm_cnt=0, all duty=0, pattern_q=0, period_start=0. coe_led_pins is all 0 (all 1 if ACTIVE_LOW=1), meaning every LED is off.
- led_pattern is registered once into pattern_q. max_duty and fade_en are sampled unregistered at the period boundary.
- Prescaler counts 0..PRESCALE-1 and wraps. tick = (prescaler==PRESCALE-1).
- pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0.
- PWM period = PRESCALE*2^PWM_BITS cycles (4096 at defaults).
- Boundary event bnd = tick && pwm_cnt==2^PWM_BITS-1. On the edge where bnd is true, pwm_cnt goes to 0 and every duty[i] updates.
- period_start is registered from bnd, so it is high exactly in the cycle where pwm_cnt==0 and prescaler==0.
- Per channel: target[i] = pattern_q[i] ? max_duty : 0.
  - fade_en=0: duty[i] <= target[i].
  - fade_en=1: if duty<target, duty <= min(duty+FADE_STEP, target). If duty>target, duty <= max(duty-FADE_STEP, target). Otherwise duty holds.
  - Arithmetic is PWM_BITS+1 bits wide: no wrap, no overshoot, saturates at target.
- Pin on[i] = (duty[i] > pwm_cnt). coe_led_pins[i] = on[i] XOR ACTIVE_LOW, and is registered, giving 1-cycle compare-to-pin latency.
- duty=0 means always off. duty=2^PWM_BITS-1 means on for 255 of 256 steps; there is no 100% state, by design.
- Latency: a pattern change is reflected at the next boundary after pattern_q updates. Worst case is PWM period + 3 cycles.
- Direction reversal mid-ramp: the new target applies from the next boundary; the ramp turns around from the current duty.
- Simultaneous pattern change and bnd: the value registered in pattern_q before that edge is used. The new pattern takes effect at the following boundary.
- max_duty lowered below the current duty: the LED ramps down (fade_en=1) or steps down (fade_en=0).
- Reset mid-operation: pins go off immediately (asynchronously), and counters and duties return to 0. After release, fading restarts from 0.

Decomposition:
- Shared package led_pkg holds the default constants: LED_NUM=8, LED_PWM_BITS=8, LED_PRESCALE=16, LED_FADE_STEP=4.
- Sub-module led_fade_chan implements one channel: duty register, saturating ramp, compare and pin flop. It is instantiated NUM_LEDS times by a generate loop.
- The top level holds pattern_q, the prescaler, pwm_cnt and period_start.

Test Plan:
- Reset: hold rsi_reset high -> coe_led_pins=8'h00 and period_start=0. With ACTIVE_LOW=1 build -> 8'hFF. Release -> first period_start at cycle 4096.
- Static on, fade_en=0, max_duty=128, pattern=8'h01 -> from the boundary after the pattern write, pin0 is high for 128*16=2048 cycles per 4096-cycle period; pins 1..7 stay 0.
- Fade up, fade_en=1, FADE_STEP=4, max_duty=255, pattern 0->8'hFF -> duty goes 4,8,...,252,255 over 64 periods with no overshoot; every channel is identical.
- Reversal: fade up to duty=100, then pattern->0 -> next boundary duty=96, then 92..., reaching 0 after 25 periods. Pins never change value mid-period except at compare crossings.
- Edge duties: max_duty=0 with pattern=8'hFF -> all pins are constantly 0. max_duty=255 -> pin low for exactly 16 cycles per period (pwm_cnt=255).
- Async reset mid-fade (duty=60) -> pins off in the same cycle. After release, fade restarts from 0 (first boundary duty=4).
